// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for decode hazard stalls.
// Define SCOREBOARD_STATS_EN to add the stall_cycles and err outputs.
module reg_scoreboard #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  input  logic        reg2loc_D,
  input  logic        use_ra1_D,
  input  logic        use_ra2_D,
  input  logic        issue_D,
  input  logic        regWrite_D,
  input  logic [4:0]  wa_D,
  input  logic        wb_valid,
  input  logic [4:0]  wb_wa,
  input  logic        flush,
  output logic        stall_D,
  output logic [31:0] busy
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic        err
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] MAXC = CW'(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt [32];
  logic [4:0]    ra1;
  logic [4:0]    ra2;
  logic          haz1;
  logic          haz2;
  logic          full;
  logic          inc;
  logic          dec;
  logic          clr;
  logic          unused;

  assign unused = ^{instr_D[31:21], instr_D[15:10]};

  assign ra1 = instr_D[9:5];
  assign ra2 = reg2loc_D ? instr_D[4:0] : instr_D[20:16];

  assign haz1 = use_ra1_D && (cnt[ra1] != '0);
  assign haz2 = use_ra2_D && (cnt[ra2] != '0);
  assign full = regWrite_D && (cnt[wa_D] == MAXC);

  assign stall_D = issue_D &&
                   (haz1 || haz2 || full || (state == FLUSH));

  // Anything arriving alongside a flush, or while flushing, is dropped.
  assign clr = flush || (state == FLUSH);

  assign inc = issue_D && !stall_D && regWrite_D &&
               (wa_D != 5'd31) && !clr;
  assign dec = wb_valid && (cnt[wb_wa] != '0) && !clr;

  always_comb begin
    busy = '0;
    for (int r = 0; r < 32; r++) begin
      busy[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (clr) begin
          cnt[r] <= '0;
        end else if (inc && (wa_D == 5'(r)) &&
                     !(dec && (wb_wa == 5'(r)))) begin
          cnt[r] <= cnt[r] + ONE;
        end else if (dec && (wb_wa == 5'(r)) &&
                     !(inc && (wa_D == 5'(r)))) begin
          cnt[r] <= cnt[r] - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else if (flush) begin
      state <= FLUSH;
    end else begin
      unique case (state)
        RUN:     if (stall_D) state <= STALL;
        STALL:   if (!stall_D) state <= RUN;
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      err          <= 1'b0;
    end else begin
      if (stall_D && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      // Completion for a register with nothing outstanding.
      if (wb_valid && !clr && (cnt[wb_wa] == '0)) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: RAW, reg2loc, saturation,
// XZR, simultaneous events, flush and async reset.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_D;
  logic        reg2loc_D;
  logic        use_ra1_D;
  logic        use_ra2_D;
  logic        issue_D;
  logic        regWrite_D;
  logic [4:0]  wa_D;
  logic        wb_valid;
  logic [4:0]  wb_wa;
  logic        flush;
  logic        stall_D;
  logic [31:0] busy;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
  logic        err;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.DEPTH(3)) dut (
    .clk(clk),
    .reset(reset),
    .instr_D(instr_D),
    .reg2loc_D(reg2loc_D),
    .use_ra1_D(use_ra1_D),
    .use_ra2_D(use_ra2_D),
    .issue_D(issue_D),
    .regWrite_D(regWrite_D),
    .wa_D(wa_D),
    .wb_valid(wb_valid),
    .wb_wa(wb_wa),
    .flush(flush),
    .stall_D(stall_D),
    .busy(busy)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .err(err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    instr_D    = '0;
    reg2loc_D  = 1'b0;
    use_ra1_D  = 1'b0;
    use_ra2_D  = 1'b0;
    issue_D    = 1'b0;
    regWrite_D = 1'b0;
    wa_D       = '0;
    wb_valid   = 1'b0;
    wb_wa      = '0;
    flush      = 1'b0;
  endtask

  task automatic wr(input logic [4:0] r);
    issue_D    = 1'b1;
    regWrite_D = 1'b1;
    wa_D       = r;
    use_ra1_D  = 1'b0;
    use_ra2_D  = 1'b0;
  endtask

  task automatic rd1(input logic [4:0] r);
    issue_D    = 1'b1;
    regWrite_D = 1'b0;
    use_ra1_D  = 1'b1;
    use_ra2_D  = 1'b0;
    instr_D    = {22'd0, r, 5'd0};
  endtask

  task automatic wb(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_wa    = r;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    chk("rst_busy", busy, 32'h0);
    rd1(5'd3);
    settle();
    chk("rst_stall", {31'd0, stall_D}, 32'd0);
    idle();
    reset = 1'b0;
    step();

    // RAW on X3
    wr(5'd3);
    settle();
    chk("raw_wr_ok", {31'd0, stall_D}, 32'd0);
    step();
    idle();
    settle();
    chk("raw_busy", busy, 32'h0000_0008);
    rd1(5'd3);
    settle();
    chk("raw_stall_a", {31'd0, stall_D}, 32'd1);
    step();
    settle();
    chk("raw_stall_b", {31'd0, stall_D}, 32'd1);
    wb(5'd3);
    settle();
    chk("raw_no_bypass", {31'd0, stall_D}, 32'd1);
    step();
    wb_valid = 1'b0;
    settle();
    chk("raw_release", {31'd0, stall_D}, 32'd0);
    chk("raw_busy0", busy, 32'h0);
    step();
    idle();

    // reg2loc selection
    wr(5'd5);
    step();
    idle();
    settle();
    chk("r2l_busy", busy, 32'h0000_0020);
    issue_D   = 1'b1;
    use_ra2_D = 1'b1;
    reg2loc_D = 1'b1;
    instr_D   = {11'd0, 5'd6, 11'd0, 5'd5};
    settle();
    chk("r2l_sel1", {31'd0, stall_D}, 32'd1);
    reg2loc_D = 1'b0;
    settle();
    chk("r2l_sel0", {31'd0, stall_D}, 32'd0);
    idle();
    wb(5'd5);
    step();
    idle();
    settle();
    chk("r2l_clear", busy, 32'h0);

    // saturation at DEPTH=3 on X7
    for (int i = 0; i < 3; i++) begin
      wr(5'd7);
      settle();
      chk("sat_accept", {31'd0, stall_D}, 32'd0);
      step();
    end
    wr(5'd7);
    settle();
    chk("sat_full", {31'd0, stall_D}, 32'd1);
    chk("sat_busy", busy, 32'h0000_0080);
    wb(5'd7);
    settle();
    chk("sat_no_bypass", {31'd0, stall_D}, 32'd1);
    step();
    wb_valid = 1'b0;
    settle();
    chk("sat_release", {31'd0, stall_D}, 32'd0);
    step();
    idle();
    wb(5'd7);
    step();
    step();
    settle();
    chk("sat_drain2", busy, 32'h0000_0080);
    step();
    idle();
    settle();
    chk("sat_drain3", busy, 32'h0);

    // XZR
    wr(5'd31);
    settle();
    chk("xzr_wr", {31'd0, stall_D}, 32'd0);
    step();
    step();
    step();
    step();
    idle();
    settle();
    chk("xzr_busy", busy, 32'h0);
    issue_D    = 1'b1;
    use_ra1_D  = 1'b1;
    use_ra2_D  = 1'b1;
    reg2loc_D  = 1'b1;
    regWrite_D = 1'b1;
    wa_D       = 5'd31;
    instr_D    = 32'hFFFF_FFFF;
    settle();
    chk("xzr_rd", {31'd0, stall_D}, 32'd0);
    idle();

    // simultaneous increment and decrement on X2
    wr(5'd2);
    step();
    idle();
    wr(5'd2);
    wb(5'd2);
    settle();
    chk("sim_accept", {31'd0, stall_D}, 32'd0);
    step();
    idle();
    settle();
    chk("sim_keep", busy, 32'h0000_0004);
    wb(5'd2);
    step();
    idle();
    settle();
    chk("sim_cnt1", busy, 32'h0);

    // flush discards same-cycle issue and writeback
    wr(5'd9);
    step();
    idle();
    settle();
    chk("fl_pre", busy, 32'h0000_0200);
    wr(5'd10);
    wb(5'd9);
    flush = 1'b1;
    step();
    idle();
    settle();
    chk("fl_busy", busy, 32'h0);
    issue_D = 1'b1;
    settle();
    chk("fl_state", {31'd0, stall_D}, 32'd1);
    step();
    settle();
    chk("fl_run", {31'd0, stall_D}, 32'd0);
    idle();
    step();

`ifdef SCOREBOARD_STATS_EN
    wb(5'd12);
    step();
    idle();
    settle();
    chk("err_sticky", {31'd0, err}, 32'd1);
`endif

    // async reset in the middle of a stall
    wr(5'd4);
    step();
    idle();
    rd1(5'd4);
    settle();
    chk("ar_stall", {31'd0, stall_D}, 32'd1);
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_busy", busy, 32'h0);
    chk("ar_stall0", {31'd0, stall_D}, 32'd0);
`ifdef SCOREBOARD_STATS_EN
    chk("ar_stats", stall_cycles, 32'h0);
`endif
    step();
    reset = 1'b0;
    settle();
    chk("ar_post", {31'd0, stall_D}, 32'd0);
    step();
    idle();
    settle();
    chk("ar_post_busy", busy, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
